uart_rx_ascii: RTL and testbench
================================

# uart_rx_ascii

Serial receive front end for the ATM console. It deserialises 8N1 UART frames from the host terminal line and presents each received byte as `ascii_code` with a one-cycle `ready` strobe. It sits directly upstream of `user_input`, which consumes `ascii_code` and `ready` to build account numbers, passwords, currency selections and menu choices. Framing errors are flagged and dropped, never forwarded.

## Interface
- `CLKS_PER_BIT`, default 868 (100 MHz / 115200 baud): clock cycles per bit. Legal range is 4 or more. Benches use 16.
- `clk`, input, 1: system clock. All logic is rising-edge.
- `reset_n`, input, 1: reset, asynchronous and active-low.
- `rx`, input, 1: asynchronous serial line. It idles high.
- `ascii_code`, output, 8: last correctly framed byte. It holds until the next good frame.
- `ready`, output, 1: one-cycle pulse. It marks that `ascii_code` has just been updated.
- `frame_err`, output, 1: one-cycle pulse. It marks a frame whose stop bit sampled low.

## Operation
- **Synchroniser:** `rx` passes through a 2-flop synchroniser. Both flops reset to 1. The FSM sees only the synchronised signal, `rx_s`.
- **Counters:**
  - Baud counter width is $clog2(CLKS_PER_BIT).
  - Bit index is 3 bits.
  - Shift register is 8 bits, LSB first: data bit 0 arrives first and lands in `ascii_code[0]`.
- **FSM states:** IDLE, START, DATA, STOP, BREAK.
- **IDLE:**
  - When `rx_s` is 0, clear the baud counter and go to START.
  - Otherwise stay in IDLE.
- **START:**
  - At count H = CLKS_PER_BIT/2 (floor), resample `rx_s`.
  - If `rx_s` is 0, clear the baud counter and bit index and go to DATA.
  - If `rx_s` is 1, treat it as a false start (glitch) and go to IDLE with no output activity.
- **DATA:**
  - At count CLKS_PER_BIT-1, sample `rx_s` into the shift register and clear the counter.
  - After bit index 7 has been sampled, go to STOP.
- **STOP:** at count CLKS_PER_BIT-1, sample `rx_s`.
  - If it is 1: load `ascii_code` from the shift register, pulse `ready` for one cycle, and go to IDLE.
  - If it is 0: pulse `frame_err` for one cycle, leave `ascii_code` unchanged, do not pulse `ready`, and go to BREAK.
- **BREAK:** wait until `rx_s` is 1, then go to IDLE. This prevents a held-low line or a break from producing repeated frames.
- **No parity; 8 data bits only.**
- **Back-to-back frames:** IDLE is re-entered at mid-stop-bit. A start edge that immediately follows the stop bit is therefore caught without loss.
- **Output exclusivity:** `ready` and `frame_err` are never high in the same cycle.

## Timing
- **Reset values:**
  - `ascii_code` = 8'h00, `ready` = 0, `frame_err` = 0.
  - FSM = IDLE, counters = 0, synchroniser flops = 1.
- **Reset mid-frame:** the frame is aborted immediately and asynchronously. After release, reception resumes at the first falling edge on `rx_s`.
- **Frame timing:** let t0 be the first cycle in which `rx_s` is low while in IDLE, and N = CLKS_PER_BIT.
  - Start bit is validated at t0+H.
  - Data bit i (0..7) is sampled at t0+H+(i+1)·N.
  - Stop bit is sampled at t0+H+9·N.
  - `ready` or `frame_err` is high in cycle t0+H+9·N+1.
  - `ascii_code` is valid in that same cycle and afterwards.
- **Pin-to-t0 latency:** 2 cycles (synchroniser).
- **False start:** a low pulse on `rx_s` shorter than H cycles never leaves START→IDLE with any output change.
- **Handshake with `user_input`:** there is no back-pressure. The consumer must accept `ascii_code` in the `ready` cycle; it stays stable for at least 10·N−H cycles after that.
- **Baud tolerance:** mid-bit sampling tolerates about ±4% baud mismatch.

## Test plan
All scenarios use CLKS_PER_BIT=16, so H=8.

1. **Reset:** hold `reset_n` low for 5 cycles while toggling `rx` → `ascii_code`=00, `ready`=0, `frame_err`=0 throughout. With `rx` high after release → no pulses.
2. **Single byte:** send 8'h63 ('c') → exactly one `ready` pulse at t0+153, with `ascii_code`=8'h63. `frame_err` stays 0.
3. **Back-to-back bytes:** send 8'h31, 8'h32, 8'h0D with zero idle between frames (stop bit followed directly by the next start) → three `ready` pulses, spaced 160 cycles apart, carrying 31, 32, 0D in order.
4. **Glitch rejection:** drive `rx` low for 5 cycles, then high → no `ready`, no `frame_err`, FSM back in IDLE. A following 8'h35 is received correctly.
5. **Framing error:** received byte 8'h63 is held, then send 8'h41 with the stop bit at 0, and hold `rx` low for 20 bit-times → exactly one `frame_err` pulse, no `ready`, `ascii_code` stays 63. After `rx` returns high, sending 8'h34 → `ready` with `ascii_code`=34.
6. **Reset mid-frame:** assert `reset_n` low during data bit 4 of 8'hAA → outputs go to 0 immediately. Release with `rx` high, then send 8'h39 → a single `ready` with `ascii_code`=39.

Source files
------------

// File: rtl/uart_rx_ascii.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, framed bytes out as ascii_code + ready strobe.
// Latency: ready/frame_err assert H+9*N+1 cycles after the start edge reaches rx_s (pin adds 2 cycles).
// No backpressure: ascii_code holds until the next good frame, and the consumer must take it on ready.
module uart_rx_ascii #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] ascii_code,
    output logic       ready,
    output logic       frame_err
);

    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    // The cycle that leaves IDLE is count 0, so START checks H-1 to land on t0+H.
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t        state, state_nxt;
    logic          rx_m, rx_s;
    logic [CW-1:0] baud_cnt, baud_cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shift_dat, shift_dat_nxt;
    logic [7:0]    ascii_nxt;
    logic          ready_nxt, frame_err_nxt;

    // Synchroniser resets to the idle-high line level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_dat  <= '0;
            ascii_code <= '0;
            ready      <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            baud_cnt   <= baud_cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shift_dat  <= shift_dat_nxt;
            ascii_code <= ascii_nxt;
            ready      <= ready_nxt;
            frame_err  <= frame_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        baud_cnt_nxt  = baud_cnt;
        bit_idx_nxt   = bit_idx;
        shift_dat_nxt = shift_dat;
        ascii_nxt     = ascii_code;
        ready_nxt     = 1'b0;
        frame_err_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    baud_cnt_nxt = '0;
                    state_nxt    = ST_START;
                end
            end
            ST_START: begin
                if (baud_cnt == HALF_M1) begin
                    if (!rx_s) begin
                        baud_cnt_nxt = '0;
                        bit_idx_nxt  = '0;
                        state_nxt    = ST_DATA;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (baud_cnt == FULL_M1) begin
                    baud_cnt_nxt  = '0;
                    shift_dat_nxt = {rx_s, shift_dat[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_nxt = ST_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt + CNT_ONE;
                end
            end
            ST_STOP: begin
                // Leaving at mid-stop-bit leaves half a bit to catch an immediate next start.
                if (baud_cnt == FULL_M1) begin
                    baud_cnt_nxt = '0;
                    if (rx_s) begin
                        ascii_nxt = shift_dat;
                        ready_nxt = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = ST_BREAK;
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt + CNT_ONE;
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_ascii.sv
// Scoreboarded bench for uart_rx_ascii at 16 clocks per bit: each frame sent queues its expected
// code, pulse type and cycle; a monitor pops and compares on every ready/frame_err pulse.
module tb_uart_rx_ascii;

    localparam int N = 16;
    // Drive at negedge -> 2 sync edges to t0, then pulse in cycle t0+H+9N+1.
    localparam int PULSE_OFS = 2 + N / 2 + 9 * N + 1;

    typedef struct {
        logic [7:0] code;
        int         cyc;
        bit         err;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic       rx;
    logic [7:0] ascii_code;
    logic       ready;
    logic       frame_err;

    int         n_cmp;
    int         n_bad;
    int         cyc;
    logic [7:0] last_good;
    exp_t       exp_q[$];

    uart_rx_ascii #(.CLKS_PER_BIT(N)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .ascii_code (ascii_code),
        .ready      (ready),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic send_byte(input logic [7:0] b, input bit stop);
        exp_t e;
        e.code = b;
        e.cyc  = cyc + PULSE_OFS;
        e.err  = !stop;
        exp_q.push_back(e);
        rx = 1'b0;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (N) @(negedge clk);
        end
        rx = stop;
        repeat (N) @(negedge clk);
    endtask

    task automatic monitor(input int ncyc, output int n_rdy, output int n_ferr);
        exp_t       e;
        logic [7:0] want;
        n_rdy  = 0;
        n_ferr = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (ready || frame_err) begin
                n_cmp++;
                if (ready && frame_err) begin
                    n_bad++;
                    $display("FAIL excl: ready=1 frame_err=1 at cycle %0d, required at most one high", cyc);
                end else if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected: ready=%0b frame_err=%0b code=%h at cycle %0d, required no pulse",
                             ready, frame_err, ascii_code, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (ready) n_rdy++;
                    else       n_ferr++;
                    want = e.err ? last_good : e.code;
                    if (frame_err !== e.err || cyc != e.cyc || ascii_code !== want) begin
                        n_bad++;
                        $display("FAIL frame: got err=%0b code=%h cycle=%0d, required err=%0b code=%h cycle=%0d",
                                 frame_err, ascii_code, cyc, e.err, want, e.cyc);
                    end
                    if (!e.err) last_good = e.code;
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing: %0d expected pulses never seen, required 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        int r, f;
        reset_n = 1'b0;
        rx      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rx = ~rx;
            #1;
            n_cmp++;
            if (ascii_code !== 8'h00 || ready !== 1'b0 || frame_err !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold: code=%h ready=%b ferr=%b, required 00 0 0", ascii_code, ready, frame_err);
            end
        end
        @(negedge clk);
        rx      = 1'b1;
        reset_n = 1'b1;
        monitor(60, r, f);
        n_cmp++;
        if (r != 0 || f != 0) begin
            n_bad++;
            $display("FAIL reset_idle: ready=%0d ferr=%0d pulses, required 0 0", r, f);
        end
    endtask

    task automatic test_single();
        int r, f;
        @(negedge clk);
        fork
            send_byte(8'h63, 1'b1);
            monitor(200, r, f);
        join
        n_cmp++;
        if (r != 1 || f != 0) begin
            n_bad++;
            $display("FAIL single_count: ready=%0d ferr=%0d, required 1 0", r, f);
        end
    endtask

    task automatic test_back_to_back();
        int r, f;
        @(negedge clk);
        fork
            begin
                send_byte(8'h31, 1'b1);
                send_byte(8'h32, 1'b1);
                send_byte(8'h0D, 1'b1);
            end
            monitor(520, r, f);
        join
        n_cmp++;
        if (r != 3 || f != 0) begin
            n_bad++;
            $display("FAIL b2b_count: ready=%0d ferr=%0d, required 3 0", r, f);
        end
    endtask

    task automatic test_glitch();
        int r, f;
        @(negedge clk);
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        monitor(60, r, f);
        n_cmp++;
        if (r != 0 || f != 0 || ascii_code !== 8'h0D) begin
            n_bad++;
            $display("FAIL glitch: ready=%0d ferr=%0d code=%h, required 0 0 0d", r, f, ascii_code);
        end
        fork
            send_byte(8'h35, 1'b1);
            monitor(200, r, f);
        join
        n_cmp++;
        if (r != 1 || f != 0) begin
            n_bad++;
            $display("FAIL glitch_after: ready=%0d ferr=%0d, required 1 0", r, f);
        end
    endtask

    task automatic test_frame_err();
        int r, f;
        @(negedge clk);
        fork
            begin
                send_byte(8'h63, 1'b1);
                send_byte(8'h41, 1'b0);
                rx = 1'b0;
                repeat (20 * N) @(negedge clk);
                rx = 1'b1;
                repeat (2 * N) @(negedge clk);
                send_byte(8'h34, 1'b1);
            end
            monitor(1200, r, f);
        join
        n_cmp++;
        if (r != 2 || f != 1) begin
            n_bad++;
            $display("FAIL ferr_count: ready=%0d ferr=%0d, required 2 1", r, f);
        end
        n_cmp++;
        if (ascii_code !== 8'h34) begin
            n_bad++;
            $display("FAIL ferr_recover: code=%h, required 34", ascii_code);
        end
    endtask

    task automatic test_reset_mid();
        int         r, f;
        logic [7:0] b;
        b = 8'hAA;
        @(negedge clk);
        rx = 1'b0;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (N) @(negedge clk);
        end
        rx = b[4];
        repeat (N / 2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (ascii_code !== 8'h00 || ready !== 1'b0 || frame_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid: code=%h ready=%b ferr=%b, required 00 0 0", ascii_code, ready, frame_err);
        end
        last_good = 8'h00;
        rx = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        fork
            send_byte(8'h39, 1'b1);
            monitor(200, r, f);
        join
        n_cmp++;
        if (r != 1 || f != 0 || ascii_code !== 8'h39) begin
            n_bad++;
            $display("FAIL reset_resume: ready=%0d ferr=%0d code=%h, required 1 0 39", r, f, ascii_code);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        last_good = 8'h00;
        reset_n   = 1'b0;
        rx        = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
